// File: rtl/instr_fetch.sv
// instr_fetch: PC/credit-based instruction fetch with in-order buffer and redirect flush.
// Responses that were in flight at a redirect are counted in r_drop and discarded on return.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_C = (CW + 2)'(FIFO_DEPTH);
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_out, r_drop, r_count;
    logic [31:0]   r_qi [FIFO_DEPTH];
    logic [31:0]   r_qp [FIFO_DEPTH];
    logic [31:0]   r_tp [FIFO_DEPTH];
    logic [PW-1:0] r_qwr, r_qrd, r_twr, r_trd;

    logic w_run, w_credit, w_redir, w_gnt, w_drop_rsp, w_acc_rsp, w_push, w_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // dropped responses still hold a credit until they return
    assign w_run      = r_state == RUN;
    assign w_credit   = {2'b00, r_out} + {2'b00, r_drop} + {2'b00, r_count} < DEPTH_C;
    assign w_redir    = w_run & redirect_valid;
    assign imem_req   = w_run & ~redirect_valid & w_credit;
    assign imem_addr  = r_pc;
    assign w_gnt      = imem_req & imem_gnt;
    assign w_drop_rsp = imem_rvalid & (r_drop != '0);
    assign w_acc_rsp  = imem_rvalid & (r_drop == '0) & (r_out != '0);
    assign w_push     = w_acc_rsp & ~w_redir;
    assign if_valid   = r_count != '0;
    assign w_pop      = if_valid & if_ready & ~w_redir;
    assign if_instr   = if_valid ? r_qi[r_qrd] : '0;
    assign if_pc      = if_valid ? r_qp[r_qrd] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_count <= '0;
            r_qwr   <= '0;
            r_qrd   <= '0;
            r_twr   <= '0;
            r_trd   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_qi[i] <= '0;
                r_qp[i] <= '0;
                r_tp[i] <= '0;
            end
        end else begin
            r_state <= RUN;
            if (w_redir) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_drop  <= r_drop + r_out - CW'(w_drop_rsp | w_acc_rsp);
                r_out   <= '0;
                r_count <= '0;
                r_qwr   <= '0;
                r_qrd   <= '0;
                r_twr   <= '0;
                r_trd   <= '0;
            end else begin
                if (w_gnt) begin
                    r_pc        <= r_pc + 32'd4;
                    r_tp[r_twr] <= r_pc;
                    r_twr       <= inc(r_twr);
                end
                if (w_drop_rsp)
                    r_drop <= r_drop - 1'b1;
                if (w_push) begin
                    r_qi[r_qwr] <= imem_rdata;
                    r_qp[r_qwr] <= r_tp[r_trd];
                    r_qwr       <= inc(r_qwr);
                    r_trd       <= inc(r_trd);
                end
                if (w_pop)
                    r_qrd <= inc(r_qrd);
                r_out   <= r_out + CW'(w_gnt) - CW'(w_acc_rsp);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
